// File: rtl/lz77_pkg.sv
// rtl/lz77_pkg.sv - shared LZ77 widths, token type and limit helpers
package lz77_pkg;

    localparam int LZ_DIST_WIDTH        = 4;
    localparam int LZ_LEN_WIDTH         = 4;
    localparam int LZ_WINDOW_ADDR_WIDTH = 4;

    // Token as exchanged with the decompressor.
    typedef struct packed {
        logic [LZ_DIST_WIDTH-1:0] distance;
        logic [LZ_LEN_WIDTH-1:0]  length;
        logic [7:0]               literal;
        logic                     last;
    } token_t;

    // Largest usable distance: limited by both the distance field and the window depth.
    function automatic int max_dist(input int dist_w, input int win_aw);
        int by_field;
        int by_window;
        by_field  = (1 << dist_w) - 1;
        by_window = 1 << win_aw;
        return (by_field < by_window) ? by_field : by_window;
    endfunction

    function automatic int max_len(input int len_w);
        return (1 << len_w) - 1;
    endfunction

endpackage

// File: rtl/lz77_prio_enc.sv
// rtl/lz77_prio_enc.sv - lowest-set-bit encoder returning a 1-based index
module lz77_prio_enc #(
    parameter int WIDTH = 15,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] mask_i,
    output logic [IDX_W-1:0] idx_o
);

    // Bit i stands for distance i+1; scan downwards so the lowest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/lz77_comp_core.sv
// rtl/lz77_comp_core.sv - streaming greedy LZ77 compressor with shift-register window
module lz77_comp_core
    import lz77_pkg::*;
#(
    parameter int DIST_WIDTH        = LZ_DIST_WIDTH,
    parameter int LEN_WIDTH         = LZ_LEN_WIDTH,
    parameter int WINDOW_ADDR_WIDTH = LZ_WINDOW_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIST_WIDTH-1:0] out_distance,
    output logic [LEN_WIDTH-1:0]  out_length,
    output logic [7:0]            out_literal,
    output logic                  out_last
);

    localparam int MAXD  = max_dist(DIST_WIDTH, WINDOW_ADDR_WIDTH);
    localparam int MAXL  = max_len(LEN_WIDTH);
    localparam int DEPTH = 1 << WINDOW_ADDR_WIDTH;
    localparam int CNT_W = WINDOW_ADDR_WIDTH + 1;

    // Only the entries the compare can reach are stored; deeper bytes are never matched.
    logic [7:0]            hist_q [1:MAXD];
    logic [CNT_W-1:0]      hist_count_q, hist_count_d;
    logic [LEN_WIDTH-1:0]  match_len_q, match_len_d;
    logic [MAXD-1:0]       cand_mask_q, cand_mask_d;
    logic [MAXD-1:0]       hit, next_mask;
    logic                  out_valid_q, out_valid_d;
    logic [DIST_WIDTH-1:0] dist_q, dist_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [7:0]            lit_q, lit_d;
    logic                  last_q, last_d;
    logic                  accept, terminate;
    logic [DIST_WIDTH-1:0] enc_idx;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    lz77_prio_enc #(
        .WIDTH (MAXD),
        .IDX_W (DIST_WIDTH)
    ) u_prio_enc (
        .mask_i (cand_mask_q),
        .idx_o  (enc_idx)
    );

    // Parallel compare of the incoming byte against every valid pre-shift history slot.
    always_comb begin
        hit = '0;
        for (int d = 1; d <= MAXD; d++) begin
            hit[d-1] = (hist_q[d] == in_byte) && (CNT_W'(d) <= hist_count_q);
        end
    end

    // Greedy match extension / token termination and output-register next state.
    always_comb begin
        hist_count_d = hist_count_q;
        match_len_d  = match_len_q;
        cand_mask_d  = cand_mask_q;
        out_valid_d  = out_valid_q;
        dist_d       = dist_q;
        len_d        = len_q;
        lit_d        = lit_q;
        last_d       = last_q;
        next_mask    = ((match_len_q == '0) ? {MAXD{1'b1}} : cand_mask_q) & hit;
        terminate    = in_last || (next_mask == '0) || (match_len_q == LEN_WIDTH'(MAXL));

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_last) begin
                hist_count_d = '0;
            end else if (hist_count_q != CNT_W'(DEPTH)) begin
                hist_count_d = hist_count_q + CNT_W'(1);
            end

            if (terminate) begin
                out_valid_d = 1'b1;
                dist_d      = (match_len_q == '0) ? '0 : enc_idx;
                len_d       = match_len_q;
                lit_d       = in_byte;
                last_d      = in_last;
                match_len_d = '0;
                cand_mask_d = '0;
            end else begin
                match_len_d = match_len_q + LEN_WIDTH'(1);
                cand_mask_d = next_mask;
            end
        end
    end

    // History window shifts on every accepted byte; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            hist_q[1] <= in_byte;
            for (int d = 2; d <= MAXD; d++) begin
                hist_q[d] <= hist_q[d-1];
            end
        end
    end

    // Match state and token output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_count_q <= '0;
            match_len_q  <= '0;
            cand_mask_q  <= '0;
            out_valid_q  <= 1'b0;
            dist_q       <= '0;
            len_q        <= '0;
            lit_q        <= '0;
            last_q       <= 1'b0;
        end else begin
            hist_count_q <= hist_count_d;
            match_len_q  <= match_len_d;
            cand_mask_q  <= cand_mask_d;
            out_valid_q  <= out_valid_d;
            dist_q       <= dist_d;
            len_q        <= len_d;
            lit_q        <= lit_d;
            last_q       <= last_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_distance = dist_q;
    assign out_length   = len_q;
    assign out_literal  = lit_q;
    assign out_last     = last_q;

endmodule

// File: tb/tb_lz77_comp_core.sv
// tb/tb_lz77_comp_core.sv - randomized self-checking bench for lz77_comp_core
module tb_lz77_comp_core;

    localparam int MAXD = 15;
    localparam int MAXL = 15;

    typedef struct {
        int d;
        int l;
        int lit;
        int last;
    } tok_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_byte = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_distance;
    logic [3:0] out_length;
    logic [7:0] out_literal;
    logic       out_last;

    int total = 0;
    int bad   = 0;

    logic [7:0] stim_b[$];
    bit         stim_l[$];
    tok_t       exp_q[$];
    tok_t       got_q[$];

    lz77_comp_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_distance (out_distance),
        .out_length   (out_length),
        .out_literal  (out_literal),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input string s, input bit with_last);
        for (int i = 0; i < s.len(); i++) begin
            stim_b.push_back(s[i]);
            stim_l.push_back(with_last && (i == s.len() - 1));
        end
    endtask

    // Greedy reference: at each token start, every distance up to min(MAXD, bytes
    // already seen in this frame) is a candidate; keep the survivors while the
    // next byte still matches, then emit (smallest survivor, length, literal).
    function automatic void model();
        int s = 0;
        int p = 0;
        exp_q.delete();
        while (p < stim_b.size()) begin
            int len = 0;
            int cands[$];
            for (int d = 1; d <= MAXD && d <= p - s; d++) cands.push_back(d);
            forever begin
                int q = p + len;
                int nxt[$];
                tok_t t;
                if (q >= stim_b.size()) begin
                    p = stim_b.size();
                    break;
                end
                foreach (cands[i]) if (stim_b[q - cands[i]] == stim_b[q]) nxt.push_back(cands[i]);
                if (stim_l[q] || len == MAXL || nxt.size() == 0) begin
                    t.d    = (len == 0) ? 0 : cands[0];
                    t.l    = len;
                    t.lit  = stim_b[q];
                    t.last = stim_l[q];
                    exp_q.push_back(t);
                    p = q + 1;
                    if (stim_l[q]) s = p;
                    break;
                end
                cands = nxt;
                len++;
            end
        end
    endfunction

    // mode 0: always ready; 1: out_ready low 5 cycles after each token; 2: random both sides
    task automatic run_stream(input string name, input int mode);
        int   idx = 0;
        int   stall = (mode == 1) ? 5 : 0;
        int   guard = 0;
        bit   pend = 0;
        logic [16:0] pv = '0;
        logic [16:0] cur;
        model();
        got_q.delete();
        while ((idx < stim_b.size() || got_q.size() < exp_q.size()) && guard < 5000) begin
            @(negedge clk);
            guard++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (stall == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (idx < stim_b.size() && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_byte  = stim_b[idx];
                in_last  = stim_l[idx];
            end else begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            #1;
            cur = {out_distance, out_length, out_literal, out_last};
            chk($sformatf("%s_in_ready", name), in_ready, !(out_valid && !out_ready));
            if (pend) chk($sformatf("%s_hold", name), {out_valid, cur}, {1'b1, pv});
            pend = out_valid && !out_ready;
            pv   = cur;
            if (out_valid && out_ready) begin
                tok_t t;
                t.d = out_distance; t.l = out_length; t.lit = out_literal; t.last = out_last;
                got_q.push_back(t);
                if (mode == 1) stall = 5;
            end else if (stall > 0) begin
                stall--;
            end
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk($sformatf("%s_drained", name), out_valid, 0);
        chk($sformatf("%s_tok_count", name), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_tok%0d", name, i),
                {got_q[i].d[7:0], got_q[i].l[7:0], got_q[i].lit[7:0], got_q[i].last[7:0]},
                {exp_q[i].d[7:0], exp_q[i].l[7:0], exp_q[i].lit[7:0], exp_q[i].last[7:0]});
        end
        if (stim_l.size() > 0 && stim_l[stim_l.size() - 1]) begin
            logic [7:0] dec[$];
            int diffs = 0;
            foreach (got_q[i]) begin
                for (int k = 0; k < got_q[i].l; k++) begin
                    if (got_q[i].d == 0 || got_q[i].d > dec.size()) dec.push_back(8'h00);
                    else dec.push_back(dec[dec.size() - got_q[i].d]);
                end
                dec.push_back(8'(got_q[i].lit));
            end
            if (dec.size() != stim_b.size()) diffs++;
            for (int i = 0; i < dec.size() && i < stim_b.size(); i++) if (dec[i] != stim_b[i]) diffs++;
            chk($sformatf("%s_roundtrip", name), diffs, 0);
        end
        stim_b.delete();
        stim_l.delete();
    endtask

    task automatic chk_tok(input string tag, input int i, input int d, input int l, input int lit, input int last);
        if (i < got_q.size()) begin
            chk(tag, {got_q[i].d[7:0], got_q[i].l[7:0], got_q[i].lit[7:0], got_q[i].last[7:0]},
                     {d[7:0], l[7:0], lit[7:0], last[7:0]});
        end else begin
            chk(tag, 32'hffff_ffff, {d[7:0], l[7:0], lit[7:0], last[7:0]});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_fields", {out_distance, out_length, out_literal, out_last}, 0);
        chk("reset_in_ready", in_ready, 1);

        add_frame("1010ABABX", 1);
        run_stream("s1010", 0);
        chk_tok("s1010_spec0", 0, 0, 0, "1", 0);
        chk_tok("s1010_spec2", 2, 2, 2, "A", 0);
        chk_tok("s1010_spec4", 4, 2, 2, "X", 1);

        add_frame("AAAAAAAAAAAAAAAAAAAA", 1);
        run_stream("twentyA", 0);
        chk_tok("twentyA_spec0", 0, 0, 0, "A", 0);
        chk_tok("twentyA_spec1", 1, 1, 15, "A", 0);
        chk_tok("twentyA_spec2", 2, 1, 2, "A", 1);

        add_frame("1010ABABX", 1);
        run_stream("stall", 1);
        chk_tok("stall_spec2", 2, 2, 2, "A", 0);

        add_frame("ABCDEFGHIJKLMNOPA", 1);
        run_stream("window", 0);
        chk_tok("window_spec16", 16, 0, 0, "A", 1);

        add_frame("AB", 1);
        run_stream("frame1", 0);
        add_frame("AB", 1);
        run_stream("frame2", 0);
        chk_tok("frame2_spec0", 0, 0, 0, "A", 0);
        chk_tok("frame2_spec1", 1, 0, 0, "B", 1);

        add_frame("ABA", 0);
        run_stream("pre_reset", 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midmatch_reset_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        add_frame("C", 1);
        run_stream("post_reset", 0);
        chk_tok("post_reset_spec0", 0, 0, 0, "C", 1);

        for (int r = 0; r < 6; r++) begin
            int alph = $urandom_range(2, 20);
            int nfr  = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                int len = $urandom_range(1, 45);
                for (int i = 0; i < len; i++) begin
                    stim_b.push_back(8'(8'h61 + $urandom_range(0, alph - 1)));
                    stim_l.push_back(i == len - 1);
                end
            end
            run_stream($sformatf("rand%0d", r), (r % 3 == 0) ? 1 : 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lz77_comp_core.md
Name: lz77_comp_core

Overview:
Streaming greedy LZ77 compressor. It is the encoder counterpart of lz77_decomp_core.
- Consumes one raw byte per handshake.
- Emits (distance, length, literal) tokens with the same semantics the decompressor consumes.
- The history window is a shift register with parallel compare; match search is greedy with the smallest distance winning.
- Sits between the byte-stream ingress and the token channel feeding lz77_decomp_core, or an AXI-Stream packer.

Parameters:
DIST_WIDTH, 4, width of out_distance; largest encodable distance is 2^DIST_WIDTH-1.
LEN_WIDTH, 4, width of out_length; MAX_LEN = 2^LEN_WIDTH-1.
WINDOW_ADDR_WIDTH, 4, history depth = 2^WINDOW_ADDR_WIDTH bytes; MAX_DIST = min(2^DIST_WIDTH-1, 2^WINDOW_ADDR_WIDTH).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  raw byte valid.
in_ready  out  1  byte accepted when in_valid && in_ready.
in_byte  in  8  raw byte.
in_last  in  1  final byte of frame.
out_valid  out  1  token valid.
out_ready  in  1  token consumer ready.
out_distance  out  DIST_WIDTH  back-reference distance, 0 = none.
out_length  out  LEN_WIDTH  bytes to copy before literal.
out_literal  out  8  literal byte appended after the copy.
out_last  out  1  token ends frame.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low (rst_n).
- Reset state:
  - out_valid=0; out_distance, out_length, out_literal and out_last = 0.
  - hist_count=0, match_len=0, cand_mask=0.
  - History contents are don't-care.
  - in_ready=1 from the first cycle after reset deassertion.
- Token semantics: the decoder copies out_length bytes byte-by-byte from out_distance back, then emits out_literal.
  - Overlap (distance < length) is legal.
  - (0,0,b) is a pure literal.
- History: hist[1..2^WINDOW_ADDR_WIDTH], where hist[1] is the most recently accepted byte.
  - On every accepted byte, hist shifts (hist[d] <= hist[d-1], hist[1] <= in_byte).
  - hist_count increments, saturating at depth.
- Compare: for d in 1..MAX_DIST, hit[d] = (hist[d]==in_byte) && (d <= hist_count).
  - Uses pre-shift history.
  - base = all-ones if match_len==0, else cand_mask.
  - next = base & hit.
- Per accepted byte, in this priority order:
  1. If in_last, OR next==0, OR match_len==MAX_LEN: terminate.
     - Load the output register with distance = lowest set index of cand_mask (0 if match_len==0), length = match_len, literal = in_byte, last = in_last.
     - Clear match_len and cand_mask.
  2. Otherwise extend: match_len++, cand_mask <= next. No token is produced.
- The last byte is never absorbed into a match.
- After a token with out_last is loaded, hist_count clears. Frames are independent; no cross-frame references.
- in_ready = !out_valid || out_ready. A byte may be accepted in the same cycle the pending token is consumed.
- Latency: the token is registered and out_valid rises the cycle after its terminating byte is accepted. A stream of literals sustains 1 byte/cycle.
- Output is held stable while out_valid && !out_ready. out_valid drops after the handshake unless a new token is loaded in the same cycle.
- in_valid low mid-match: state holds indefinitely.
- Reset mid-match or with a pending token: everything is discarded, no token is emitted, and the next byte starts a new frame.
- Distances beyond MAX_DIST are never matched, even if hist_count exceeds them.

Decomposition:
- Package lz77_pkg holds:
  - DIST_WIDTH, LEN_WIDTH and WINDOW_ADDR_WIDTH defaults.
  - token_t struct {distance, length, literal, last}, shared with lz77_decomp_core.
  - MAX_DIST/MAX_LEN functions.
- One sub-module, lz77_prio_enc: lowest-set-bit encoder, MAX_DIST-wide mask to DIST_WIDTH index.

Test Plan:
- "1010ABABX", last on X, out_ready=1 -> tokens (0,0,'1'), (0,0,'0'), (2,2,'A'), (0,0,'B'), (2,2,'X',last=1). Feeding these to lz77_decomp_core reproduces the input.
- Twenty 'A's, last on the final one -> (0,0,'A'), (1,15,'A'), (1,2,'A',last).
- Same stream as the first scenario with out_ready held 0 for 5 cycles after each token:
  - in_ready is low while a token is pending.
  - Tokens are unchanged and none are lost or duplicated.
- "ABCDEFGHIJKLMNOPA" (A repeats at distance 16 > MAX_DIST=15) -> 17 literal tokens (0,0,x).
- Two frames "AB"+last then "AB"+last -> second frame yields (0,0,'A'), (0,0,'B',last). No back-reference crosses the frame boundary.
- rst_n pulsed low mid-match after "ABA" (match_len=1) -> out_valid=0 immediately. The following "C"+last yields (0,0,'C',last).
